// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the ALU sequencer: FSM states and operand-order selects.
package alu_seq_ctrl_pkg;

  localparam int ST_W  = 3;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Listed as {x,y}; A is bank row 0, B is bank row 1.
  typedef enum logic [SEL_W-1:0] {
    SEL_BB = 2'b00,
    SEL_BA = 2'b01,
    SEL_AB = 2'b10,
    SEL_AA = 2'b11
  } sel_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request, ALU and result signals of the sequencer bundled as one port.
interface alu_seq_ctrl_if #(
  parameter int DW  = 4,
  parameter int OPW = 3,
  parameter int RW  = 2*DW
);
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic [1:0]     in_sel;
  logic [OPW-1:0] in_op;
  logic           in_reuse;

  logic [DW-1:0]  alu_x;
  logic [DW-1:0]  alu_y;
  logic [OPW-1:0] alu_op;
  logic [RW-1:0]  alu_res;

  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  out_res;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_op, in_reuse, alu_res, out_ready,
    input  in_ready, alu_x, alu_y, alu_op, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_op, in_reuse, alu_res, out_ready,
    output in_ready, alu_x, alu_y, alu_op, out_valid, out_res
  );
endinterface

// File: rtl/alu_reg_bank.sv
// Two-row operand bank: row 0 holds A, row 1 holds B; read mux returns {x,y}.
module alu_reg_bank
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wa,
  input  logic [DW-1:0] wb,
  input  sel_e          sel,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y
);

  logic [1:0][DW-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (wr) begin
      mem_d[0] = wa;
      mem_d[1] = wb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  always_comb begin
    x = mem_q[0];
    y = mem_q[0];
    unique case (sel)
      SEL_BB: begin x = mem_q[1]; y = mem_q[1]; end
      SEL_BA: begin x = mem_q[1]; y = mem_q[0]; end
      SEL_AB: begin x = mem_q[0]; y = mem_q[1]; end
      SEL_AA: begin x = mem_q[0]; y = mem_q[0]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer: accept request, load bank, pick operand order, run ALU, hold result until taken.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DW  = 4,
  parameter int OPW = 3,
  parameter int RW  = 2*DW
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  output logic [CNT_W-1:0] op_count
);

  state_e             state_q, state_d;
  logic [DW-1:0]      a_q, a_d, b_q, b_d;
  sel_e               sel_q, sel_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [DW-1:0]      x_q, x_d, y_q, y_d;
  logic [RW-1:0]      res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               bank_wr;
  logic [DW-1:0]      bank_x, bank_y;

  alu_reg_bank #(.DW(DW)) u_bank (
    .clk (clk),
    .rst (rst),
    .wr  (bank_wr),
    .wa  (a_q),
    .wb  (b_q),
    .sel (sel_q),
    .x   (bank_x),
    .y   (bank_y)
  );

  // Handshake outputs depend only on state, never on in_valid/out_ready.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sel_d         = sel_q;
    op_d          = op_q;
    x_d           = x_q;
    y_d           = y_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    bank_wr       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.alu_x     = '0;
    bus.alu_y     = '0;
    bus.alu_op    = '0;

    unique case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          sel_d   = sel_e'(bus.in_sel);
          op_d    = bus.in_op;
          state_d = bus.in_reuse ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        bank_wr = 1'b1;
        state_d = ST_READ;
      end
      ST_READ: begin
        x_d     = bank_x;
        y_d     = bank_y;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        bus.alu_x  = x_q;
        bus.alu_y  = y_q;
        bus.alu_op = op_q;
        res_d      = bus.alu_res;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= SEL_BB;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_res = res_q;
  assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with an adder standing in for the ALU.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam int DW  = 4;
  localparam int OPW = 3;
  localparam int RW  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] op_count;

  alu_seq_ctrl_if #(.DW(DW), .OPW(OPW), .RW(RW)) bus ();

  alu_seq_ctrl #(.DW(DW), .OPW(OPW), .RW(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  assign bus.alu_res = RW'(bus.alu_x) + RW'(bus.alu_y);

  typedef struct {
    int x;
    int y;
    int res;
    int op;
    int lat;
    int t0;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   npops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: operand/latency checks on the first DONE cycle, result checks on handoff.
  logic prev_v = 1'b0;
  int   prev_x = 0, prev_y = 0, prev_op = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      prev_v  = 1'b0;
    end else begin
      if (bus.out_valid && !prev_v) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_result: got out_res %0d with empty queue", bus.out_res);
        end else begin
          chk("exec_x", prev_x, q[0].x);
          chk("exec_y", prev_y, q[0].y);
          chk("exec_op", prev_op, q[0].op);
          chk("latency", cyc - q[0].t0 + 1, q[0].lat);
          chk("alu_x_idle", int'(bus.alu_x), 0);
        end
      end
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        chk("out_res", int'(bus.out_res), q[0].res);
        chk("op_count_pre", int'(op_count), exp_cnt);
        void'(q.pop_front());
        exp_cnt = (exp_cnt + 1) % 256;
        npops++;
      end
      prev_v  = bus.out_valid;
      prev_x  = int'(bus.alu_x);
      prev_y  = int'(bus.alu_y);
      prev_op = int'(bus.alu_op);
    end
  end

  task automatic issue(input int a, input int b, input int sel, input int op,
                       input int reuse, input int ex, input int ey, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", int'(bus.in_ready), 1);
    bus.in_a     = DW'(a);
    bus.in_b     = DW'(b);
    bus.in_sel   = 2'(sel);
    bus.in_op    = OPW'(op);
    bus.in_reuse = reuse[0];
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (push) begin
      e.x   = ex;
      e.y   = ey;
      e.res = ex + ey;
      e.op  = op;
      e.lat = reuse ? 3 : 4;
      e.t0  = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  function automatic void pick(input int a, input int b, input int sel,
                               output int x, output int y);
    x = sel[1] ? a : b;
    y = sel[0] ? a : b;
  endfunction

  initial begin
    int ox[4];
    int oy[4];
    int n;
    int base;
    int px, py;
    ox = '{9, 9, 2, 2};
    oy = '{9, 2, 9, 2};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.in_op     = '0;
    bus.in_reuse  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_out_res", int'(bus.out_res), 0);
    chk("rst_alu_x", int'(bus.alu_x), 0);
    chk("rst_alu_op", int'(bus.alu_op), 0);
    rst = 1'b0;

    // Basic
    issue(3, 5, 2, 1, 0, 3, 5, 1'b1);
    drain(50);
    chk("basic_cnt", int'(op_count), 1);

    // Ordering: A=2, B=9 under each select
    for (int s = 0; s < 4; s++) issue(2, 9, s, s + 2, 0, ox[s], oy[s], 1'b1);
    drain(100);
    chk("order_cnt", int'(op_count), 5);

    // Reuse of stored bank contents
    issue(7, 1, 2, 2, 0, 7, 1, 1'b1);
    issue(0, 0, 1, 3, 1, 1, 7, 1'b1);
    drain(50);
    chk("reuse_cnt", int'(op_count), 7);

    // Backpressure: result held 10 cycles, requests ignored
    bus.out_ready = 1'b0;
    issue(4, 4, 2, 5, 0, 4, 4, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", int'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 4'hf;
      bus.in_b     = 4'h3;
      bus.in_sel   = 2'b11;
      bus.in_reuse = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_out_res", int'(bus.out_res), 8);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_op_count", int'(op_count), 7);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain(20);
    chk("bp_cnt_after", int'(op_count), 8);
    chk("bp_in_ready_after", int'(bus.in_ready), 1);

    // Reset during EXEC aborts the operation and clears the bank
    issue(5, 6, 2, 4, 0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("midop_exec_x", int'(bus.alu_x), 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_out_valid", int'(bus.out_valid), 0);
    chk("midop_op_count", int'(op_count), 0);
    chk("midop_in_ready", int'(bus.in_ready), 1);
    chk("midop_alu_x", int'(bus.alu_x), 0);
    @(negedge clk);
    rst = 1'b0;
    issue(9, 9, 3, 6, 1, 0, 0, 1'b1);
    drain(50);
    chk("midop_cnt_after", int'(op_count), 1);

    // Wrap: clean reset, then 256 back-to-back operations
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = npops;
    for (int i = 0; i < 256; i++) begin
      pick(i % 16, (i / 16) % 16, i % 4, px, py);
      issue(i % 16, (i / 16) % 16, i % 4, i % 8, 0, px, py, 1'b1);
    end
    drain(100);
    chk("wrap_cnt", int'(op_count), 0);
    chk("wrap_ops", npops - base, 256);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

endmodule
